debug_seg_driver: RTL

DEBUG_SEG_DRIVER -- requirements
Module: debug_seg_driver

---
 rtl/debug_seg_driver_if.sv | 29 ++
 rtl/debug_seg_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_seg_driver_if.sv
// Avalon-MM slave bus bundle for the debug 7-segment / LED driver.
// Latency: n/a (signal bundle only).
// Backpressure: none; the slave has no waitrequest and a fixed read latency of 1.
//
// Signals: avs_address[2:0] word address, avs_read / avs_write strobes,
//          avs_writedata[31:0], avs_readdata[31:0].
interface debug_seg_driver_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/debug_seg_driver.sv
// Register-mapped driver for six active-low 7-segment digits and ten LEDs, hex or BCD display.
// Latency: read data 1 cycle; hex digits 2 cycles after a write; decimal digits 26 cycles after start.
// Backpressure: none; every bus access completes in one cycle, a busy conversion is restarted or aborted.
//
// Ports: clk, reset_n (async, active-low); avs (Avalon-MM slave bundle);
//        seg_out[41:0] digit n at [7n+6:7n], active-low; led_out[9:0] active-high.
module debug_seg_driver #(
    parameter int DEFAULT_BLINK_DIV = 25000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    debug_seg_driver_if.slave          avs,
    output logic [41:0]                seg_out,
    output logic [9:0]                 led_out
);
    localparam logic [25:0] LP_DIV_RST = 26'(DEFAULT_BLINK_DIV);
    localparam logic [41:0] LP_DASHES  = {6{7'h3F}};
    localparam logic [41:0] LP_ZEROS   = {6{7'h40}};

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    function automatic logic [6:0] f_hex7(input logic [3:0] i_nib);
        case (i_nib)
            4'h0: f_hex7 = 7'h40;  4'h1: f_hex7 = 7'h79;
            4'h2: f_hex7 = 7'h24;  4'h3: f_hex7 = 7'h30;
            4'h4: f_hex7 = 7'h19;  4'h5: f_hex7 = 7'h12;
            4'h6: f_hex7 = 7'h02;  4'h7: f_hex7 = 7'h78;
            4'h8: f_hex7 = 7'h00;  4'h9: f_hex7 = 7'h10;
            4'hA: f_hex7 = 7'h08;  4'hB: f_hex7 = 7'h03;
            4'hC: f_hex7 = 7'h46;  4'hD: f_hex7 = 7'h21;
            4'hE: f_hex7 = 7'h06;  default: f_hex7 = 7'h0E;
        endcase
    endfunction

    // Architectural registers
    logic [23:0] r_value;
    logic        r_dec;
    logic [5:0]  r_blank;
    logic [5:0]  r_blink;
    logic [25:0] r_blink_div;
    logic [9:0]  r_leds;
    logic        r_ovf;
    logic [25:0] r_blink_cnt;
    logic        r_phase;
    // Conversion datapath and display pipeline
    logic [23:0] r_shift;
    logic [23:0] r_bcd;
    logic [4:0]  r_iter;
    logic [41:0] r_disp;
    logic [31:0] r_rdata;
    state_t      r_state;

    state_t      w_state_nxt;
    logic        w_busy, w_conv, w_done;
    logic        w_wr_value, w_wr_ctrl, w_wr_div, w_wr_leds;
    logic        w_start, w_abort, w_start_ovf;
    logic [23:0] w_start_val;
    logic [23:0] w_bcd_adj;
    logic [41:0] w_hex_seg, w_bcd_seg, w_seg_nxt;
    logic [31:0] w_rd_mux;
    logic        w_unused_wd;

    assign w_wr_value = avs.avs_write && (avs.avs_address == 3'd0);
    assign w_wr_ctrl  = avs.avs_write && (avs.avs_address == 3'd1);
    assign w_wr_div   = avs.avs_write && (avs.avs_address == 3'd2);
    assign w_wr_leds  = avs.avs_write && (avs.avs_address == 3'd3);
    assign w_unused_wd = &{1'b0, avs.avs_writedata[31:26]};

    // A VALUE write in decimal mode, or a DEC 0->1 edge, (re)starts conversion.
    // The VALUE write converts the incoming data, not the stale register.
    assign w_start     = (w_wr_value && r_dec) || (w_wr_ctrl && avs.avs_writedata[0] && !r_dec);
    assign w_abort     = w_wr_ctrl && !avs.avs_writedata[0];
    assign w_start_val = w_wr_value ? avs.avs_writedata[23:0] : r_value;
    assign w_start_ovf = (w_start_val > 24'd999999);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = w_start_ovf ? S_DONE : S_CONV;
        end else begin
            case (r_state)
                S_CONV:  w_state_nxt = (r_iter == 5'd23) ? S_DONE : S_CONV;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_conv = (r_state == S_CONV);
        w_done = (r_state == S_DONE);
    end

    // Shift-add-3: bias every BCD nibble >= 5 before the next left shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < 6; n++) begin
            if (r_bcd[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_hex_seg = '0;
        w_bcd_seg = '0;
        for (int n = 0; n < 6; n++) begin
            w_hex_seg[7*n +: 7] = f_hex7(r_value[4*n +: 4]);
            w_bcd_seg[7*n +: 7] = f_hex7(r_bcd[4*n +: 4]);
        end
    end

    // BLANK wins over BLINK; both force the digit dark.
    always_comb begin
        w_seg_nxt = r_disp;
        for (int n = 0; n < 6; n++) begin
            if (r_blank[n] || (r_blink[n] && r_phase)) w_seg_nxt[7*n +: 7] = 7'h7F;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs.avs_address)
            3'd0:    w_rd_mux = {8'd0, r_value};
            3'd1:    w_rd_mux = {10'd0, r_blink, 2'd0, r_blank, 7'd0, r_dec};
            3'd2:    w_rd_mux = {6'd0, r_blink_div};
            3'd3:    w_rd_mux = {22'd0, r_leds};
            3'd4:    w_rd_mux = {30'd0, r_ovf, w_busy};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value     <= '0;
            r_dec       <= 1'b0;
            r_blank     <= '0;
            r_blink     <= '0;
            r_blink_div <= LP_DIV_RST;
            r_leds      <= '0;
            r_ovf       <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_iter      <= '0;
            r_disp      <= LP_ZEROS;
            r_rdata     <= '0;
            seg_out     <= '1;
            led_out     <= '0;
        end else begin
            if (w_wr_value) r_value <= avs.avs_writedata[23:0];
            if (w_wr_ctrl) begin
                r_dec   <= avs.avs_writedata[0];
                r_blank <= avs.avs_writedata[13:8];
                r_blink <= avs.avs_writedata[21:16];
            end
            if (w_wr_leds) r_leds <= avs.avs_writedata[9:0];

            if (w_start) begin
                r_shift <= w_start_val;
                r_bcd   <= '0;
                r_iter  <= '0;
                r_ovf   <= w_start_ovf;
            end else begin
                if (w_abort) r_ovf <= 1'b0;
                if (w_conv) begin
                    r_bcd   <= {w_bcd_adj[22:0], r_shift[23]};
                    r_shift <= {r_shift[22:0], 1'b0};
                    r_iter  <= r_iter + 5'd1;
                end
            end

            // Hex tracks VALUE continuously; decimal only commits a finished,
            // non-superseded conversion so partial results never show.
            if (!r_dec) begin
                r_disp <= w_hex_seg;
            end else if (w_done && !w_start) begin
                r_disp <= r_ovf ? LP_DASHES : w_bcd_seg;
            end

            if (w_wr_div) begin
                r_blink_div <= avs.avs_writedata[25:0];
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_div == 26'd0) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_cnt == r_blink_div - 26'd1) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 26'd1;
            end

            if (avs.avs_read) r_rdata <= w_rd_mux;

            seg_out <= w_seg_nxt;
            led_out <= r_leds;
        end
    end

    assign avs.avs_readdata = r_rdata;

endmodule
